// File: rtl/alu_pkg.sv
// alu_pkg: opcode and sequencer state encodings shared by the ALU arbiter slice.
package alu_pkg;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_EQ  = 4'd6;
   localparam logic [3:0] OP_LT  = 4'd7;
   localparam logic [3:0] OP_GT  = 4'd8;
   localparam logic [3:0] OP_MAX = 4'd8;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/alu_32bit.sv
// alu_32bit: combinational 32-bit ALU with zero, signed-overflow and illegal-opcode flags.
module alu_32bit #(
   parameter logic [3:0] OP_MAX = 4'd8
) (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [31:0] result,
   output logic        zero,
   output logic        overflow,
   output logic        illegal
);
   import alu_pkg::*;
   logic [31:0] r;
   always_comb begin
      r = '0;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOT:  r = ~a;
         OP_EQ:   r = {31'd0, a == b};
         OP_LT:   r = {31'd0, a < b};
         OP_GT:   r = {31'd0, a > b};
         default: r = '0;
      endcase
   end
   assign illegal  = op > OP_MAX;
   assign result   = illegal ? '0 : r;
   assign zero     = result == '0;
   assign overflow = !illegal && (
                     (op == OP_ADD && a[31] == b[31] && result[31] != a[31]) ||
                     (op == OP_SUB && a[31] != b[31] && result[31] != a[31]));
endmodule

// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl: two-port valid/ready arbiter sequencing operations through one shared alu_32bit.
// Each operation walks IDLE -> EXEC -> RESP; operands and results are registered.
module alu_arb_ctrl #(
   parameter bit         RR_EN  = 1'b1,
   parameter logic [3:0] OP_MAX = 4'd8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req1_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req0_op,
   input  logic [3:0]  req1_op,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   input  logic        rsp0_ready,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_overflow,
   output logic        rsp_illegal,
   output logic        busy
);
   import alu_pkg::*;
   logic [1:0]  state;
   logic        rr_ptr;
   logic        grant_id;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [3:0]  op_q;
   logic        gnt;
   logic        idle;
   logic [31:0] alu_r;
   logic        alu_z;
   logic        alu_v;
   logic        alu_i;
   assign idle = state == ST_IDLE;
   // gnt names the winning port; only meaningful when at least one valid is high
   assign gnt        = (req0_valid && req1_valid) ? (RR_EN ? rr_ptr : 1'b0) : req1_valid;
   assign req0_ready = idle && req0_valid && !gnt;
   assign req1_ready = idle && req1_valid && gnt;
   assign rsp0_valid = state == ST_RESP && !grant_id;
   assign rsp1_valid = state == ST_RESP && grant_id;
   assign busy       = !idle;
   alu_32bit #(.OP_MAX(OP_MAX)) u_alu (
      .a        (a_q),
      .b        (b_q),
      .op       (op_q),
      .result   (alu_r),
      .zero     (alu_z),
      .overflow (alu_v),
      .illegal  (alu_i)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         rr_ptr       <= 1'b0;
         grant_id     <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_illegal  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (req0_ready || req1_ready) begin
               a_q      <= gnt ? req1_a : req0_a;
               b_q      <= gnt ? req1_b : req0_b;
               op_q     <= gnt ? req1_op : req0_op;
               grant_id <= gnt;
               if (RR_EN) rr_ptr <= ~gnt;
               state    <= ST_EXEC;
            end
            ST_EXEC: begin
               rsp_result   <= alu_r;
               rsp_zero     <= alu_z;
               rsp_overflow <= alu_v;
               rsp_illegal  <= alu_i;
               state        <= ST_RESP;
            end
            ST_RESP: if (grant_id ? rsp1_ready : rsp0_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// tb_alu_arb_ctrl: directed bench for alu_arb_ctrl, round-robin and fixed-priority instances.
module tb_alu_arb_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
   logic [3:0]  op0 = '0, op1 = '0;
   logic        rr0 = 1'b0, rr1 = 1'b0;
   logic        r0, r1, s0, s1, z, ov, il, bsy;
   logic [31:0] res;
   logic        f_r0, f_r1, f_s0, f_s1, f_z, f_ov, f_il, f_bsy;
   logic [31:0] f_res;
   int          total = 0, passed = 0, fails = 0;

   always #5 clk = ~clk;

   alu_arb_ctrl #(.RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req1_valid(v1), .req0_ready(r0), .req1_ready(r1),
      .req0_a(a0), .req1_a(a1), .req0_b(b0), .req1_b(b1), .req0_op(op0), .req1_op(op1),
      .rsp0_valid(s0), .rsp1_valid(s1), .rsp0_ready(rr0), .rsp1_ready(rr1),
      .rsp_result(res), .rsp_zero(z), .rsp_overflow(ov), .rsp_illegal(il), .busy(bsy)
   );

   alu_arb_ctrl #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req1_valid(v1), .req0_ready(f_r0), .req1_ready(f_r1),
      .req0_a(a0), .req1_a(a1), .req0_b(b0), .req1_b(b1), .req0_op(op0), .req1_op(op1),
      .rsp0_valid(f_s0), .rsp1_valid(f_s1), .rsp0_ready(rr0), .rsp1_ready(rr1),
      .rsp_result(f_res), .rsp_zero(f_z), .rsp_overflow(f_ov), .rsp_illegal(f_il), .busy(f_bsy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request on port p, wait for its grant, and stop in the first RESP cycle.
   task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      int n = 0;
      if (p == 0) begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
      else begin v1 = 1'b1; a1 = a; b1 = b; op1 = op; end
      #1;
      while (!(p == 0 ? r0 : r1) && n < 20) begin
         @(posedge clk); #2; n++;
      end
      chk("req_ready", p == 0 ? r0 : r1, 1);
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      a0 = 32'hDEAD_BEEF; b0 = 32'hDEAD_BEEF; a1 = 32'hDEAD_BEEF; b1 = 32'hDEAD_BEEF;
      chk("exec_busy", bsy, 1);
      chk("exec_no_rsp", {s1, s0}, 0);
      @(posedge clk); #1;
      chk(p == 0 ? "rsp0_valid" : "rsp1_valid", {s1, s0}, p == 0 ? 2'b01 : 2'b10);
   endtask

   task automatic ack(input int p);
      if (p == 0) rr0 = 1'b1; else rr1 = 1'b1;
      @(posedge clk); #1;
      rr0 = 1'b0; rr1 = 1'b0;
      chk("idle_after_ack", {bsy, s1, s0}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      v0 = 1'b1; v1 = 1'b1;
      #3;
      chk("reset_busy", bsy, 0);
      chk("reset_rsp_valid", {s1, s0}, 0);
      chk("reset_result", res, 0);
      chk("reset_flags", {z, ov, il}, 0);
      v0 = 1'b0; v1 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ADD with signed overflow on port 0
      issue(0, 32'h7FFF_FFFF, 32'h1, 4'd0);
      chk("add_result", res, 32'h8000_0000);
      chk("add_flags_z_ov_il", {z, ov, il}, 3'b010);
      ack(0);

      // SUB on port 1 with response back-pressure and a competing port-0 request
      issue(1, 32'd5, 32'd5, 4'd1);
      v0 = 1'b1; a0 = 32'd77; b0 = 32'd1; op0 = 4'd0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("hold_req_ready", {r1, r0}, 0);
         chk("hold_rsp_valid", {s1, s0}, 2'b10);
         chk("hold_result", res, 0);
         chk("hold_flags", {z, ov, il}, 3'b100);
         @(posedge clk); #1;
      end
      v0 = 1'b0;
      ack(1);

      // illegal opcode
      issue(0, 32'd3, 32'd4, 4'hF);
      chk("illegal_result", res, 0);
      chk("illegal_flags", {z, ov, il}, 3'b101);
      ack(0);

      // unsigned compares
      issue(0, 32'hFFFF_FFFF, 32'h1, 4'd7);
      chk("lt_result", res, 0);
      chk("lt_zero", z, 1);
      ack(0);
      issue(0, 32'hFFFF_FFFF, 32'h1, 4'd8);
      chk("gt_result", res, 1);
      chk("gt_flags", {z, ov, il}, 0);
      ack(0);

      // both ports contending from reset, responses always accepted
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      v0 = 1'b1; a0 = 32'd10; b0 = 32'd1; op0 = 4'd0;
      v1 = 1'b1; a1 = 32'd20; b1 = 32'd1; op1 = 4'd0;
      rr0 = 1'b1; rr1 = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         logic g;
         while (!(r0 || r1) && n < 20) begin
            @(posedge clk); #2; n++;
         end
         chk("rr_grant", {r1, r0}, (k % 2) ? 2'b10 : 2'b01);
         chk("fp_grant", {f_r1, f_r0}, 2'b01);
         g = r1;
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk("rr_result", res, g ? 32'd21 : 32'd11);
         chk("rr_rsp_valid", {s1, s0}, g ? 2'b10 : 2'b01);
         chk("fp_result", f_res, 32'd11);
         @(posedge clk); #1;
      end
      v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
      @(posedge clk); #1;

      // asynchronous reset while an operation is in EXEC
      v0 = 1'b1; a0 = 32'd9; b0 = 32'd9; op0 = 4'd0;
      #1;
      chk("pre_reset_grant", r0, 1);
      @(posedge clk); #1;
      v0 = 1'b0;
      chk("pre_reset_exec", bsy, 1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_busy", bsy, 0);
      chk("async_reset_rsp_valid", {s1, s0}, 0);
      chk("async_reset_result", res, 0);
      chk("async_reset_flags", {z, ov, il}, 0);
      @(posedge clk); #1;
      chk("reset_no_rsp", {bsy, s1, s0}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; op0 = 4'd0;
      v1 = 1'b1; a1 = 32'd100; b1 = 32'd2; op1 = 4'd0;
      #1;
      chk("post_reset_grant", {r1, r0}, 2'b01);
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_rsp", {s1, s0}, 2'b01);
      chk("post_reset_result", res, 32'd3);
      ack(0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
